symbiface_mouse_acc: RTL and testbench

//  SYMBiFACE II PS/2 mouse port with accumulating deltas. PS/2 packets are

---
 rtl/symbiface_mouse_acc.sv | 149 ++++++++++++++
 tb/tb_symbiface_mouse_acc.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/symbiface_mouse_acc.sv
// SYMBiFACE II PS/2 mouse port: packet deltas are summed into saturating accumulators and
// drained as clamped report bytes, one byte per read. SYMBIFACE_WHEEL_EN adds the wheel accumulator.
module symbiface_mouse_acc #(
  parameter int ACC_W = 12,
  parameter bit INV_Y = 1'b0
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [24:0] ps2_mouse,
  input  logic [15:0] ps2_mouse_ext,
  input  logic        sel,
  output logic [7:0]  dout,
  output logic        pending
);

  localparam logic signed [ACC_W-1:0] XY_HI = ACC_W'(31);
  localparam logic signed [ACC_W-1:0] XY_LO = -ACC_W'(32);
`ifdef SYMBIFACE_WHEEL_EN
  localparam logic signed [ACC_W-1:0] WH_HI = ACC_W'(15);
  localparam logic signed [ACC_W-1:0] WH_LO = -ACC_W'(16);
`endif

  logic signed [ACC_W-1:0] acc_x_q, acc_x_d;
  logic signed [ACC_W-1:0] acc_y_q, acc_y_d;
  logic [2:0]              btn_q, btn_d;
  logic                    btn_flag_q, btn_flag_d;
  logic [7:0]              dout_q, dout_d;
  logic                    sel_q, sel_d;
  logic                    toggle_q, toggle_d;
  logic                    armed_q, armed_d;
`ifdef SYMBIFACE_WHEEL_EN
  logic signed [ACC_W-1:0] acc_w_q, acc_w_d;
  logic signed [ACC_W-1:0] dw, sw;
`endif

  logic signed [ACC_W-1:0] dx, dy, dy_raw, sx, sy;
  logic                    pkt, rd, btn_clr;
  logic                    unused_in;

  // One extra bit of headroom: the two top bits disagreeing means the sum left the range.
  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W:0] sum;
    sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (sum[ACC_W] != sum[ACC_W-1])
      sat_add = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      sat_add = sum[ACC_W-1:0];
  endfunction

  function automatic logic signed [ACC_W-1:0] clamp(input logic signed [ACC_W-1:0] a,
                                                    input logic signed [ACC_W-1:0] lo,
                                                    input logic signed [ACC_W-1:0] hi);
    if (a > hi)      clamp = hi;
    else if (a < lo) clamp = lo;
    else             clamp = a;
  endfunction

  always_comb begin
    dx     = {{(ACC_W-9){ps2_mouse[4]}}, ps2_mouse[4], ps2_mouse[15:8]};
    dy_raw = {{(ACC_W-9){ps2_mouse[5]}}, ps2_mouse[5], ps2_mouse[23:16]};
    dy     = INV_Y ? -dy_raw : dy_raw;
`ifdef SYMBIFACE_WHEEL_EN
    dw     = {{(ACC_W-8){ps2_mouse_ext[7]}}, ps2_mouse_ext[7:0]};
    sw     = '0;
`endif

    // The toggle is only compared once armed, so edges seen during reset never count.
    pkt      = armed_q && (ps2_mouse[24] != toggle_q);
    toggle_d = ps2_mouse[24];
    armed_d  = 1'b1;
    rd       = sel && !sel_q;
    sel_d    = sel;

    sx      = '0;
    sy      = '0;
    btn_clr = 1'b0;
    dout_d  = dout_q;
    if (!sel) begin
      dout_d = 8'hFF;
    end else if (rd) begin
      if (acc_y_q != '0) begin
        sy     = clamp(acc_y_q, XY_LO, XY_HI);
        dout_d = {2'b10, sy[5:0]};
      end else if (acc_x_q != '0) begin
        sx     = clamp(acc_x_q, XY_LO, XY_HI);
        dout_d = {2'b01, sx[5:0]};
`ifdef SYMBIFACE_WHEEL_EN
      end else if (acc_w_q != '0) begin
        sw     = clamp(acc_w_q, WH_LO, WH_HI);
        dout_d = {3'b111, sw[4:0]};
`endif
      end else if (btn_flag_q) begin
        dout_d  = {5'b11000, btn_q};
        btn_clr = 1'b1;
      end else begin
        dout_d = 8'h00;
      end
    end

    // s is taken from the pre-update value and removed after the packet has been added.
    acc_x_d = (pkt ? sat_add(acc_x_q, dx) : acc_x_q) - sx;
    acc_y_d = (pkt ? sat_add(acc_y_q, dy) : acc_y_q) - sy;
`ifdef SYMBIFACE_WHEEL_EN
    acc_w_d = (pkt ? sat_add(acc_w_q, dw) : acc_w_q) - sw;
`endif
    btn_d      = pkt ? ps2_mouse[2:0] : btn_q;
    btn_flag_d = pkt ? 1'b1 : (btn_clr ? 1'b0 : btn_flag_q);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      acc_x_q    <= '0;
      acc_y_q    <= '0;
      btn_q      <= '0;
      btn_flag_q <= 1'b0;
      dout_q     <= 8'hFF;
      sel_q      <= 1'b0;
      toggle_q   <= 1'b0;
      armed_q    <= 1'b0;
`ifdef SYMBIFACE_WHEEL_EN
      acc_w_q    <= '0;
`endif
    end else begin
      acc_x_q    <= acc_x_d;
      acc_y_q    <= acc_y_d;
      btn_q      <= btn_d;
      btn_flag_q <= btn_flag_d;
      dout_q     <= dout_d;
      sel_q      <= sel_d;
      toggle_q   <= toggle_d;
      armed_q    <= armed_d;
`ifdef SYMBIFACE_WHEEL_EN
      acc_w_q    <= acc_w_d;
`endif
    end
  end

  assign dout = dout_q;

`ifdef SYMBIFACE_WHEEL_EN
  assign pending   = (|acc_x_q) | (|acc_y_q) | (|acc_w_q) | btn_flag_q;
  assign unused_in = ^{ps2_mouse[7:6], ps2_mouse[3], ps2_mouse_ext[15:8]};
`else
  assign pending   = (|acc_x_q) | (|acc_y_q) | btn_flag_q;
  assign unused_in = ^{ps2_mouse[7:6], ps2_mouse[3], ps2_mouse_ext};
`endif

endmodule

// File: tb/tb_symbiface_mouse_acc.sv
// Bench for symbiface_mouse_acc (default build, wheel disabled): directed and random
// packets/reads checked against an integer model of the accumulate-and-drain rules.
module tb_symbiface_mouse_acc;

  localparam int ACC_W = 12;
  localparam int AMAX  = (1 << (ACC_W - 1)) - 1;
  localparam int AMIN  = -(1 << (ACC_W - 1));

  logic        clk_sys;
  logic        reset_n;
  logic [24:0] ps2_mouse;
  logic [15:0] ps2_mouse_ext;
  logic        sel;
  logic [7:0]  dout;
  logic        pending;

  int checks = 0;
  int errors = 0;

  int mx = 0, my = 0, mflag = 0;
  logic [2:0] mbtn = '0;

  symbiface_mouse_acc #(.ACC_W(ACC_W), .INV_Y(1'b0)) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ps2_mouse    (ps2_mouse),
    .ps2_mouse_ext(ps2_mouse_ext),
    .sel          (sel),
    .dout         (dout),
    .pending      (pending)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  function automatic int sat(input int v);
    if (v > AMAX) return AMAX;
    if (v < AMIN) return AMIN;
    return v;
  endfunction

  function automatic int clampi(input int v);
    if (v > 31) return 31;
    if (v < -32) return -32;
    return v;
  endfunction

  function automatic logic [7:0] model_pending();
    return (mx != 0 || my != 0 || mflag != 0) ? 8'h01 : 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_pkt(input int dx, input int dy, input logic [2:0] b);
    logic [8:0] dx9, dy9;
    dx9 = 9'(dx);
    dy9 = 9'(dy);
    ps2_mouse[24]    = ~ps2_mouse[24];
    ps2_mouse[23:16] = dy9[7:0];
    ps2_mouse[15:8]  = dx9[7:0];
    ps2_mouse[7:6]   = 2'($urandom);
    ps2_mouse[5]     = dy9[8];
    ps2_mouse[4]     = dx9[8];
    ps2_mouse[3]     = 1'($urandom);
    ps2_mouse[2:0]   = b;
    ps2_mouse_ext    = 16'($urandom);
  endtask

  task automatic packet(input int dx, input int dy, input logic [2:0] b);
    @(negedge clk_sys);
    drive_pkt(dx, dy, b);
    mx = sat(mx + dx);
    my = sat(my + dy);
    mbtn = b;
    mflag = 1;
    @(posedge clk_sys); #1;
    chk("pkt_pending", {7'b0, pending}, model_pending());
  endtask

  // One sel pulse, optionally with a packet landing on the read edge and sel held an extra cycle.
  task automatic pulse(input bit pkt, input int dx, input int dy, input logic [2:0] b, input bit hold);
    int sx, sy;
    logic [7:0] exp;
    @(negedge clk_sys);
    sx = 0; sy = 0; exp = 8'h00;
    if (my != 0) begin
      sy = clampi(my); exp = 8'h80 | 8'(sy & 63);
    end else if (mx != 0) begin
      sx = clampi(mx); exp = 8'h40 | 8'(sx & 63);
    end else if (mflag != 0) begin
      exp = 8'hC0 | {5'b0, mbtn}; mflag = 0;
    end
    if (pkt) begin
      drive_pkt(dx, dy, b);
      mx = sat(mx + dx) - sx;
      my = sat(my + dy) - sy;
      mbtn = b;
      mflag = 1;
    end else begin
      mx -= sx;
      my -= sy;
    end
    sel = 1'b1;
    @(posedge clk_sys); #1;
    chk("read", dout, exp);
    chk("read_pending", {7'b0, pending}, model_pending());
    if (hold) begin
      @(posedge clk_sys); #1;
      chk("hold", dout, exp);
    end
    @(negedge clk_sys);
    sel = 1'b0;
    @(posedge clk_sys); #1;
    chk("idle", dout, 8'hFF);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && model_pending() != 8'h00; i++) pulse(0, 0, 0, 3'b0, 0);
    chk("drained", {7'b0, pending}, 8'h00);
    pulse(0, 0, 0, 3'b0, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    sel = 1'b1;
    ps2_mouse = '0;
    ps2_mouse_ext = '0;
    repeat (2) @(posedge clk_sys);
    #1;
    chk("rst_dout", dout, 8'hFF);
    chk("rst_pending", {7'b0, pending}, 8'h00);
    @(negedge clk_sys);
    ps2_mouse[24] = 1'b1;
    @(posedge clk_sys); #1;
    chk("rst_dout2", dout, 8'hFF);
    @(negedge clk_sys);
    sel = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    chk("post_rst_pending", {7'b0, pending}, 8'h00);
    pulse(0, 0, 0, 3'b0, 0);

    packet(5, -3, 3'b001);
    pulse(0, 0, 0, 3'b0, 0);
    pulse(0, 0, 0, 3'b0, 0);
    pulse(0, 0, 0, 3'b0, 1);
    pulse(0, 0, 0, 3'b0, 0);

    repeat (3) packet(100, 0, 3'b010);
    drain();

    repeat (30) packet(127, 0, 3'b100);
    drain();

    repeat (10) packet(-256, -256, 3'b011);
    drain();

    packet(0, 10, 3'b000);
    pulse(1, 0, 40, 3'b101, 0);
    drain();

    packet(0, 0, 3'b110);
    pulse(0, 0, 0, 3'b0, 0);
    pulse(0, 0, 0, 3'b0, 0);

    for (int n = 0; n < 80; n++) begin
      int r, dx, dy;
      logic [2:0] b;
      r  = int'($urandom_range(0, 3));
      dx = int'($urandom_range(0, 511)) - 256;
      dy = int'($urandom_range(0, 511)) - 256;
      b  = 3'($urandom);
      case (r)
        0: packet(dx, dy, b);
        1: pulse(0, 0, 0, 3'b0, 0);
        2: pulse(1, dx, dy, b, 0);
        default: pulse(0, 0, 0, 3'b0, 1);
      endcase
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
